// File: rtl/seg7_pkg.sv
// Shared constants for the memory-mapped seven-segment display: register
// offsets, CTRL/STATUS bit positions and the hex-to-segment table.
package seg7_pkg;

  localparam logic [3:0] OFF_DIGITS = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_CYCLES = 4'hC;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_DP_LSB   = 4;
  localparam int CTRL_DP_MSB   = 7;
  localparam int STATUS_EN_BIT = 8;

  // Active-high {g,f,e,d,c,b,a}, entry 15 first.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex digit to active-high {g,f,e,d,c,b,a} decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX7_TABLE[i_hex];

endmodule

// File: rtl/mmio_seg7_display.sv
// CPU-bus seven-segment peripheral: DIGITS/CTRL/STATUS registers and a
// 4-digit multiplexed scan. Define SEG7_CYCLE_COUNTER_EN to map CYCLES at 0xC.
module mmio_seg7_display
  import seg7_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0010,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter logic [15:0] RESET_DIGITS = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] r_digits;
  logic        r_en;
  logic [3:0]  r_dp;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [3:0]  r_an;
  logic [7:0]  r_seg;

  logic [31:0] w_off;
  logic        w_in_block;
  logic        w_sel_digits;
  logic        w_sel_ctrl;
  logic        w_sel_status;
  logic        w_sel_cycles;
  logic [3:0]  w_nibble;
  logic [6:0]  w_hex_seg;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Byte lanes are ignored: decode on the word address relative to the base.
  assign w_off        = {address[31:2], 2'b00} - BASE_ADDR;
  assign w_in_block   = (w_off[31:4] == 28'd0);
  assign w_sel_digits = w_in_block && (w_off[3:0] == OFF_DIGITS);
  assign w_sel_ctrl   = w_in_block && (w_off[3:0] == OFF_CTRL);
  assign w_sel_status = w_in_block && (w_off[3:0] == OFF_STATUS);
  assign w_unused     = ^{address[1:0], write_data[31:16]};

`ifdef SEG7_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;

  assign w_sel_cycles = w_in_block && (w_off[3:0] == OFF_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles <= 32'd0;
    end else if (mem_write && w_sel_cycles) begin
      r_cycles <= 32'd0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end
`else
  assign w_sel_cycles = 1'b0;
`endif

  assign hit = w_sel_digits | w_sel_ctrl | w_sel_status | w_sel_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digits <= RESET_DIGITS;
      r_en     <= 1'b1;
      r_dp     <= 4'h0;
    end else if (mem_write) begin
      if (w_sel_digits) begin
        r_digits <= write_data[15:0];
      end
      if (w_sel_ctrl) begin
        r_en <= write_data[CTRL_EN_BIT];
        r_dp <= write_data[CTRL_DP_MSB:CTRL_DP_LSB];
      end
    end
  end

  // Scan position only advances while enabled so re-enabling resumes in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 16'd0;
      r_idx <= 2'd0;
    end else if (r_en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= 16'd0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign w_nibble = r_digits[{r_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_hex (w_nibble),
    .o_seg (w_hex_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= 4'hF;
      r_seg <= 8'hFF;
    end else if (r_en) begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= ~{r_dp[r_idx], w_hex_seg};
    end else begin
      r_an  <= 4'hF;
      r_seg <= 8'hFF;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

  always_comb begin
    w_rdata = 32'h0;
    if (mem_read) begin
      if (w_sel_digits) w_rdata = {16'h0, r_digits};
      if (w_sel_ctrl)   w_rdata = {24'h0, r_dp, 3'b000, r_en};
      if (w_sel_status) w_rdata = {23'h0, r_en, 6'h0, r_idx};
`ifdef SEG7_CYCLE_COUNTER_EN
      if (w_sel_cycles) w_rdata = r_cycles;
`endif
    end
  end

  assign read_data = w_rdata;

endmodule

// File: tb/tb_mmio_seg7_display.sv
// Scoreboard bench for mmio_seg7_display: a spec-level model predicts an/seg,
// hit and read_data per cycle; a negedge monitor pops and compares.
module tb_mmio_seg7_display;

  localparam logic [31:0] BASE    = 32'h4000_0010;
  localparam int          SDIV    = 4;
  localparam logic [15:0] RST_DIG = 16'h0000;
  localparam int          W       = 45;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  mmio_seg7_display #(
    .BASE_ADDR    (BASE),
    .SCAN_DIV     (SDIV),
    .RESET_DIGITS (RST_DIG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .hit        (hit),
    .an         (an),
    .seg        (seg)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] m_digits;
  bit          m_en;
  logic [3:0]  m_dp;
  int          m_cnt;
  int          m_idx;
  logic [31:0] m_cycles;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;

  task automatic model_reset();
    m_digits = RST_DIG;
    m_en     = 1'b1;
    m_dp     = 4'h0;
    m_cnt    = 0;
    m_idx    = 0;
    m_cycles = 32'd0;
    m_an     = 4'hF;
    m_seg    = 8'hFF;
  endtask

  function automatic int reg_index(logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == BASE)          return 0;
    if (w == BASE + 32'd4)  return 1;
    if (w == BASE + 32'd8)  return 2;
`ifdef SEG7_CYCLE_COUNTER_EN
    if (w == BASE + 32'd12) return 3;
`endif
    return -1;
  endfunction

  function automatic logic [31:0] model_read(int r);
    case (r)
      0:       return {16'h0, m_digits};
      1:       return (32'(m_dp) << 4) | 32'(m_en);
      2:       return (32'(m_en) << 8) | 32'(m_idx);
      3:       return m_cycles;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_edge();
    int         r;
    logic [3:0] nib;
    if (!reset) begin
      model_reset();
      return;
    end
    r = reg_index(address);
    if (m_en) begin
      nib   = 4'((m_digits >> (4 * m_idx)) & 16'hF);
      m_an  = 4'hF ^ (4'd1 << m_idx);
      m_seg = 8'hFF ^ {m_dp[m_idx], seg_tab[nib]};
    end else begin
      m_an  = 4'hF;
      m_seg = 8'hFF;
    end
    if (m_en) begin
      if (m_cnt == SDIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    m_cycles = m_cycles + 32'd1;
    if (mem_write && r >= 0) begin
      case (r)
        0: m_digits = write_data[15:0];
        1: begin m_en = write_data[0]; m_dp = write_data[7:4]; end
        3: m_cycles = 32'd0;
        default: ;
      endcase
    end
  endtask

  task automatic push_exp();
    int          r;
    bit          h;
    logic [31:0] rd;
    r  = reg_index(address);
    h  = (r >= 0);
    rd = (mem_read && h) ? model_read(r) : 32'h0;
    exp_q.push_back({m_an, m_seg, h, rd});
  endtask

  // ---------------- scoreboard / monitor
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("an",        32'(an),        32'(mon_e[44:41]));
      check("seg",       32'(seg),       32'(mon_e[40:33]));
      check("hit",       32'(hit),       32'(mon_e[32]));
      check("read_data", read_data,      mon_e[31:0]);
    end
  end

  // ---------------- driver tasks
  task automatic cycle(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    model_edge();
    mem_write  = we;
    mem_read   = re;
    address    = a;
    write_data = d;
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, BASE, 32'h0);
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    #1;
    model_edge();
    mem_write  = 1'b1;
    mem_read   = 1'b1;
    address    = BASE;
    write_data = 32'h0000_ABCD;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_an",  32'(an),  32'h0000_000F);
    check("async_seg", 32'(seg), 32'h0000_00FF);
    push_exp();
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return BASE - 32'd4;
    if (k == 1) return BASE + 32'd16;
    return BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus
  initial begin
    reset      = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    model_reset();

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, BASE + 32'd4, 32'h0);
    reset = 1'b1;
    cycle(1'b0, 1'b1, BASE + 32'd4, 32'h0);

    cycle(1'b1, 1'b0, BASE, 32'h0000_1234);
    idle(20);

    cycle(1'b1, 1'b0, BASE + 32'd4, 32'h0000_0051);
    idle(20);

    for (int k = 0; k < 32 && !(m_idx == 2 && m_cnt == 1); k++) idle(1);
    cycle(1'b1, 1'b0, BASE + 32'd4, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, BASE + 32'd8, 32'h0);
    cycle(1'b1, 1'b0, BASE + 32'd4, 32'h1);
    idle(10);

    cycle(1'b0, 1'b1, BASE + 32'd12, 32'h0);
    cycle(1'b1, 1'b0, BASE + 32'd12, 32'h0000_FFFF);
    cycle(1'b0, 1'b1, BASE, 32'h0);
    cycle(1'b0, 1'b0, BASE, 32'h0);
    cycle(1'b0, 1'b1, BASE + 32'd6, 32'h0);
    cycle(1'b1, 1'b0, BASE + 32'd8, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, BASE + 32'd8, 32'h0);
    idle(5);

    async_reset_mid();
    cycle(1'b0, 1'b1, BASE, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, BASE + 32'd12, 32'h0);

    cycle(1'b1, 1'b0, BASE, 32'h0000_CAFE);
    for (int i = 0; i < 2000; i++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1: cycle(1'b1, 1'b0, BASE + 32'($urandom_range(0, 3)), $urandom);
        2:    cycle(1'b1, 1'b0, BASE + 32'd4,
                    ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) != 0));
        3:    cycle(1'b1, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
        4, 5, 6: cycle(1'b0, 1'b1, rand_addr(), $urandom);
        default: cycle(1'b0, $urandom_range(0, 1) == 1, rand_addr(), 32'h0);
      endcase
    end
    idle(2);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
